multi_project_sel: RTL

//  Parametrised project multiplexer/controller for the Caravel user area. Selects one of NUM_PROJECTS
//  sub-designs via a Wishbone CTRL register, sequences its reset on every switch, routes GPIO pads
//  to/from it, and decodes per-project Wishbone windows into write strobes and read-back muxing.

---
 rtl/multi_project_sel.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multi_project_sel.sv
// Purpose: selects one of NUM_PROJECTS user projects, sequences its reset, routes pads and Wishbone windows.
// Latency: Wishbone ack/read data 1 cycle after request; pad out/oeb 1 cycle; proj_io_in combinational.
// Backpressure: none; every request is acked after one cycle and ack is never held for more than one cycle.
// Ports: wbs_* Wishbone slave (CTRL +0x00, STATUS +0x04, project p window +0x100*(p+1));
//        io_* pad side; proj_io_* per-project pad slices; proj_rdata/proj_wb_update window read/write;
//        proj_rst (active high) and proj_clk_en per project. wbs_dat_i is shared unregistered with projects.
module multi_project_sel #(
    parameter int          NUM_PROJECTS = 8,
    parameter int          IO_WIDTH     = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          RST_CYCLES   = 16
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_we_i,
    input  logic [3:0]                       wbs_sel_i,
    input  logic [31:0]                      wbs_adr_i,
    input  logic [31:0]                      wbs_dat_i,
    output logic                             wbs_ack_o,
    output logic [31:0]                      wbs_dat_o,
    input  logic [IO_WIDTH-1:0]              io_in,
    output logic [IO_WIDTH-1:0]              io_out,
    output logic [IO_WIDTH-1:0]              io_oeb,
    output logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_in,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_out,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_oeb,
    input  logic [NUM_PROJECTS*32-1:0]       proj_rdata,
    output logic [NUM_PROJECTS-1:0]          proj_wb_update,
    output logic [NUM_PROJECTS-1:0]          proj_rst,
    output logic [NUM_PROJECTS-1:0]          proj_clk_en
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESET = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [4:0] NP_W     = 5'(NUM_PROJECTS);
    localparam logic [3:0] SEL_MAX  = 4'(NUM_PROJECTS - 1);
    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [3:0] sel;
    logic       en;
    logic [7:0] cnt, cnt_nxt;

    // Bus decode
    logic        req;
    logic [31:0] off;
    logic        hit_ctrl, hit_stat, hit_win, win_run;
    logic [23:0] win_page, win_idx_full;
    logic [3:0]  win_idx;
    logic        ctrl_wr;
    logic [3:0]  new_sel;
    logic        new_en, new_soft;

    // A request is only taken when ack is low, which makes ack a one-cycle pulse
    // even when the master holds cyc/stb.
    assign req          = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign off          = wbs_adr_i - BASE_ADDR;
    assign hit_ctrl     = (off[31:2] == 30'd0);
    assign hit_stat     = (off[31:2] == 30'd1);
    assign win_page     = off[31:8];
    assign win_idx_full = win_page - 24'd1;
    assign win_idx      = win_idx_full[3:0];
    assign hit_win      = (win_page != 24'd0) && (win_page <= 24'(NUM_PROJECTS));
    assign win_run      = hit_win && (state == ST_RUN) && (win_idx == sel);

    assign ctrl_wr  = req && wbs_we_i && hit_ctrl && (wbs_sel_i == 4'hF);
    assign new_sel  = ({1'b0, wbs_dat_i[3:0]} >= NP_W) ? SEL_MAX : wbs_dat_i[3:0];
    assign new_en   = wbs_dat_i[8];
    assign new_soft = wbs_dat_i[9];

    logic unused_ok;
    assign unused_ok = &{1'b0, off[1:0], win_idx_full[23:4], wbs_dat_i[31:10], wbs_dat_i[7:4]};

    // Next-state: the reset countdown runs on its own, a CTRL write overrides it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == ST_RESET) begin
            if (cnt == 8'd0) state_nxt = ST_RUN;
            else             cnt_nxt   = cnt - 8'd1;
        end
        if (ctrl_wr) begin
            if (!new_en) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 8'd0;
            end else if ((state != ST_RUN) || (new_sel != sel) || new_soft) begin
                // Covers entry from IDLE and a restart while already counting.
                state_nxt = ST_RESET;
                cnt_nxt   = RST_LOAD;
            end
        end
    end

    logic [NUM_PROJECTS-1:0] sel_oh;
    always_comb begin
        sel_oh = '0;
        for (int p = 0; p < NUM_PROJECTS; p++) sel_oh[p] = (sel == 4'(p));
    end

    // Slice selection by one-hot loop keeps all part-select indices constant.
    logic [IO_WIDTH-1:0] run_out, run_oeb;
    logic [31:0]         win_rdata;
    always_comb begin
        proj_io_in = '0;
        run_out    = '0;
        run_oeb    = '1;
        win_rdata  = '0;
        for (int p = 0; p < NUM_PROJECTS; p++) begin
            if (sel_oh[p]) begin
                proj_io_in[p*IO_WIDTH +: IO_WIDTH] = io_in;
                run_out   = proj_io_out[p*IO_WIDTH +: IO_WIDTH];
                run_oeb   = proj_io_oeb[p*IO_WIDTH +: IO_WIDTH];
                win_rdata = proj_rdata[p*32 +: 32];
            end
        end
    end

    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        if (hit_ctrl)
            rd_mux = {23'd0, en, 4'd0, sel};
        else if (hit_stat)
            rd_mux = {8'd0, cnt, 6'd0, (state == ST_RESET), (state == ST_RUN), 4'd0, sel};
        else if (win_run)
            rd_mux = win_rdata;
    end

    // Held in reset everywhere except the running project; the selected project
    // is clocked during its reset so synchronous resets take effect.
    always_comb begin
        proj_rst    = '1;
        proj_clk_en = '0;
        if (state == ST_RESET) begin
            proj_clk_en = sel_oh;
        end else if (state == ST_RUN) begin
            proj_rst    = ~sel_oh;
            proj_clk_en = sel_oh;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state          <= ST_IDLE;
            cnt            <= 8'd0;
            sel            <= 4'd0;
            en             <= 1'b0;
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            proj_wb_update <= '0;
            io_out         <= '0;
            io_oeb         <= '1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (ctrl_wr) begin
                sel <= new_sel;
                en  <= new_en;
            end
            wbs_ack_o      <= req;
            wbs_dat_o      <= (req && !wbs_we_i) ? rd_mux : 32'd0;
            proj_wb_update <= (req && wbs_we_i && win_run) ? sel_oh : '0;
            if (state == ST_RUN) begin
                io_out <= run_out;
                io_oeb <= run_oeb;
            end else begin
                io_out <= '0;
                io_oeb <= '1;
            end
        end
    end

endmodule
